// File: rtl/uart_debug_monitor.sv
// uart_debug_monitor: single-letter ASCII command monitor between the uart byte
// interface and the CPU. Reads probe words back as hex, drives halt/step, and
// selects the probe channel shown on the seven-segment display.
module uart_debug_monitor #(
   parameter int NCH       = 8,
   parameter int DW        = 32,
   parameter int TO_CYCLES = 100_000_000
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic [NCH*DW-1:0] probe,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_re,
   output logic [7:0]        tx_data,
   output logic              tx_we,
   input  logic              tx_busy,
   output logic              cpu_halt,
   output logic              cpu_step,
   output logic [15:0]       disp,
   output logic [1:0]        led
);

   localparam int         SW       = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int         CW       = $clog2(TO_CYCLES + 1);
   localparam int         ND       = DW / 4;
   localparam logic [3:0] HEX_LEN  = 4'(ND + 2);
   localparam logic [3:0] SHORT_LEN = 4'd3;

   typedef enum logic [1:0] {IDLE, ARG, SEND} state_t;
   typedef enum logic [1:0] {R_OK, R_ERR, R_HEX} reply_t;

   state_t          state;
   reply_t          kind_q;
   logic [3:0]      idx;
   logic            guard;
   logic            arg_is_disp;
   logic [DW-1:0]   snap;
   logic [SW-1:0]   dsel;
   logic [CW-1:0]   cnt;

   logic [DW-1:0]   chan [NCH];

   genvar c;
   generate
      for (c = 0; c < NCH; c++) begin : g_chan
         assign chan[c] = probe[c*DW +: DW];
      end
   endgenerate

   // Byte idx of a reply: hex digits MSB nibble first, or 'K'/'?', then CR LF.
   function automatic logic [7:0] reply_byte(input reply_t kind, input logic [3:0] i,
                                             input logic [DW-1:0] val);
      logic [3:0] nib;
      reply_byte = 8'h0a;
      if (kind == R_HEX) begin
         if (int'(i) < ND) begin
            nib = 4'(val >> (4 * (ND - 1 - int'(i))));
            reply_byte = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
         end else if (int'(i) == ND) begin
            reply_byte = 8'h0d;
         end
      end else begin
         if (i == 4'd0)      reply_byte = (kind == R_OK) ? 8'h4b : 8'h3f;
         else if (i == 4'd1) reply_byte = 8'h0d;
      end
   endfunction

   logic          consume, timed_out, start, go_arg, set_halt, clr_halt, step, set_dsel;
   reply_t        start_kind;
   logic          hex_ok, in_range;
   logic [3:0]    hex_val;
   logic [DW-1:0] sel_val;
   logic [7:0]    start_byte;
   logic [3:0]    reply_len;

   // Command/argument decode of the byte pending at this edge.
   always_comb begin
      timed_out  = (state == ARG) && (cnt == CW'(TO_CYCLES));
      consume    = (state == IDLE || state == ARG) && rx_valid && !rx_re && !timed_out;
      hex_ok     = 1'b1;
      hex_val    = 4'h0;
      if (rx_data >= 8'h30 && rx_data <= 8'h39)      hex_val = 4'(rx_data - 8'h30);
      else if (rx_data >= 8'h41 && rx_data <= 8'h46) hex_val = 4'(rx_data - 8'h37);
      else if (rx_data >= 8'h61 && rx_data <= 8'h66) hex_val = 4'(rx_data - 8'h57);
      else                                           hex_ok  = 1'b0;
      in_range   = hex_ok && ({1'b0, hex_val} < 5'(NCH));
      sel_val    = chan[hex_val[SW-1:0]];
      start      = 1'b0;
      start_kind = R_ERR;
      go_arg     = 1'b0;
      set_halt   = 1'b0;
      clr_halt   = 1'b0;
      step       = 1'b0;
      set_dsel   = 1'b0;
      if (timed_out) begin
         start = 1'b1;
      end else if (consume && state == IDLE) begin
         case (rx_data)
            8'h72, 8'h52, 8'h64, 8'h44: go_arg = 1'b1;
            8'h68, 8'h48: begin set_halt = 1'b1; start = 1'b1; start_kind = R_OK; end
            8'h67, 8'h47: begin clr_halt = 1'b1; start = 1'b1; start_kind = R_OK; end
            8'h73, 8'h53: begin
               start = 1'b1;
               if (cpu_halt) begin
                  step       = 1'b1;
                  start_kind = R_OK;
               end
            end
            8'h0d, 8'h0a, 8'h20: ;
            default: start = 1'b1;
         endcase
      end else if (consume && state == ARG) begin
         start = 1'b1;
         if (in_range) begin
            if (arg_is_disp) begin
               set_dsel   = 1'b1;
               start_kind = R_OK;
            end else begin
               start_kind = R_HEX;
            end
         end
      end
      start_byte = reply_byte(start_kind, 4'd0, sel_val);
      reply_len  = (kind_q == R_HEX) ? HEX_LEN : SHORT_LEN;
   end

   // Main FSM with registered handshakes, CPU control and reply sequencing.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state       <= IDLE;
         kind_q      <= R_ERR;
         idx         <= '0;
         guard       <= 1'b0;
         arg_is_disp <= 1'b0;
         snap        <= '0;
         dsel        <= '0;
         cnt         <= '0;
         rx_re       <= 1'b0;
         tx_we       <= 1'b0;
         tx_data     <= '0;
         cpu_halt    <= 1'b0;
         cpu_step    <= 1'b0;
      end else begin
         rx_re    <= consume;
         cpu_step <= step;
         tx_we    <= 1'b0;
         guard    <= tx_we;
         if (set_halt) cpu_halt <= 1'b1;
         if (clr_halt) cpu_halt <= 1'b0;
         if (set_dsel) dsel <= hex_val[SW-1:0];
         case (state)
            IDLE: begin
               if (go_arg) begin
                  state       <= ARG;
                  arg_is_disp <= (rx_data == 8'h64) || (rx_data == 8'h44);
                  cnt         <= '0;
               end
            end
            ARG: begin
               if (!start) cnt <= cnt + 1'b1;
            end
            SEND: begin
               // Leave only after the last byte's guard cycle so a new
               // reply can always be issued at its consuming edge.
               if (idx < reply_len && !tx_we && !guard && !tx_busy) begin
                  tx_we   <= 1'b1;
                  tx_data <= reply_byte(kind_q, idx, snap);
                  idx     <= idx + 1'b1;
               end else if (idx == reply_len && !tx_we && !guard) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
         if (start) begin
            state  <= SEND;
            kind_q <= start_kind;
            snap   <= sel_val;
            if (!tx_busy) begin
               tx_we   <= 1'b1;
               tx_data <= start_byte;
               idx     <= 4'd1;
            end else begin
               idx <= 4'd0;
            end
         end
      end
   end

   assign disp = 16'(chan[dsel]);
   assign led  = {state != IDLE, cpu_halt};

endmodule

// File: tb/tb_uart_debug_monitor.sv
// Directed bench for uart_debug_monitor with a byte scoreboard on the TX side
// and a simple busy model of the uart transmitter.
module tb_uart_debug_monitor;

   localparam int NCH = 8;
   localparam int DW  = 32;
   localparam int TO  = 1000;

   logic              clk = 1'b0;
   logic              rstn = 1'b0;
   logic [NCH*DW-1:0] probe = '0;
   logic [7:0]        rx_data = '0;
   logic              rx_valid = 1'b0;
   logic              tx_busy = 1'b0;
   logic              rx_re, tx_we, cpu_halt, cpu_step;
   logic [7:0]        tx_data;
   logic [15:0]       disp;
   logic [1:0]        led;

   uart_debug_monitor #(.NCH(NCH), .DW(DW), .TO_CYCLES(TO)) dut (
      .clk(clk), .rstn(rstn), .probe(probe),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_re(rx_re),
      .tx_data(tx_data), .tx_we(tx_we), .tx_busy(tx_busy),
      .cpu_halt(cpu_halt), .cpu_step(cpu_step), .disp(disp), .led(led)
   );

   always #5 clk = ~clk;

   // uart transmitter: busy for a few cycles after each accepted byte
   int bcnt = 0;
   always @(posedge clk) begin
      if (!rstn) begin
         tx_busy <= 1'b0;
         bcnt    <= 0;
      end else if (tx_we) begin
         tx_busy <= 1'b1;
         bcnt    <= 4;
      end else if (bcnt > 0) begin
         bcnt <= bcnt - 1;
         if (bcnt == 1) tx_busy <= 1'b0;
      end
   end

   int         checks = 0;
   int         failures = 0;
   logic [7:0] exp_q[$];
   int         step_cnt, step_bad, tx_cnt, extra, lat;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic push_ok();
      exp_q.push_back(8'h4b); exp_q.push_back(8'h0d); exp_q.push_back(8'h0a);
   endtask

   task automatic push_err();
      exp_q.push_back(8'h3f); exp_q.push_back(8'h0d); exp_q.push_back(8'h0a);
   endtask

   task automatic push_hex(input logic [31:0] v);
      logic [3:0] n;
      for (int i = 7; i >= 0; i--) begin
         n = v[i*4 +: 4];
         exp_q.push_back((n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n}));
      end
      exp_q.push_back(8'h0d); exp_q.push_back(8'h0a);
   endtask

   task automatic set_probe(input int ch, input logic [31:0] v);
      probe[ch*DW +: DW] = v;
   endtask

   // Offer one byte, then watch TX until the scoreboard drains and the line idles.
   task automatic xfer(input logic [7:0] b, input bit mutate);
      int  first_re, first_we, idle;
      bit  pending, done;
      step_cnt = 0; step_bad = 0; tx_cnt = 0; extra = 0;
      first_re = -1; first_we = -1; idle = 0; done = 0;
      rx_data  = b;
      rx_valid = 1'b1;
      pending  = 1'b1;
      for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
         @(negedge clk);
         if (rx_re && first_re < 0) first_re = cyc;
         if (rx_re && rx_valid) begin
            rx_valid = 1'b0;
            pending  = 1'b0;
         end
         if (cpu_step) step_cnt++;
         if (cpu_step && !rx_re) step_bad++;
         if (tx_we) begin
            tx_cnt++;
            if (first_we < 0) first_we = cyc;
            if (mutate && tx_cnt == 1) set_probe(3, 32'h0);
            if (exp_q.size() == 0) extra++;
            else check("tx_byte", {24'h0, tx_data}, {24'h0, exp_q.pop_front()});
         end
         if (!pending && exp_q.size() == 0 && !tx_busy && !tx_we) idle++;
         else idle = 0;
         if (idle >= 12) done = 1;
      end
      check("xfer_done", 32'(done), 32'd1);
      check("tx_extra", 32'(extra), 32'd0);
      lat = (first_we >= 0 && first_re >= 0) ? first_we - first_re : -1;
      rx_valid = 1'b0;
      exp_q.delete();
   endtask

   initial begin
      int seen;
      set_probe(0, 32'h1111_5A5A);
      repeat (3) @(negedge clk);
      check("rst_tx_we", 32'(tx_we), 32'd0);
      check("rst_tx_data", 32'(tx_data), 32'd0);
      check("rst_rx_re", 32'(rx_re), 32'd0);
      check("rst_halt", 32'(cpu_halt), 32'd0);
      check("rst_step", 32'(cpu_step), 32'd0);
      check("rst_led", 32'(led), 32'd0);
      check("rst_disp", 32'(disp), 32'h5A5A);
      rstn = 1'b1;
      repeat (2) @(negedge clk);

      // probe read with a probe change during the reply
      set_probe(3, 32'hDEADBEEF);
      xfer("r", 0);
      check("r_no_tx", 32'(tx_cnt), 32'd0);
      push_hex(32'hDEADBEEF);
      xfer("3", 1);
      check("r3_bytes", 32'(tx_cnt), 32'd10);
      check("r3_latency", 32'(lat), 32'd0);

      // uppercase command
      set_probe(7, 32'h0123ABCD);
      xfer("R", 0);
      push_hex(32'h0123ABCD);
      xfer("7", 0);
      check("R7_bytes", 32'(tx_cnt), 32'd10);

      // halt / step / go
      push_ok(); xfer("h", 0);
      check("h_halt", 32'(cpu_halt), 32'd1);
      check("h_latency", 32'(lat), 32'd0);
      push_ok(); xfer("s", 0);
      check("s_step_cnt", 32'(step_cnt), 32'd1);
      check("s_step_align", 32'(step_bad), 32'd0);
      check("s_halt", 32'(cpu_halt), 32'd1);
      push_ok(); xfer("G", 0);
      check("g_halt", 32'(cpu_halt), 32'd0);
      push_err(); xfer("s", 0);
      check("s_nohalt_step", 32'(step_cnt), 32'd0);

      // display select
      set_probe(5, 32'hABCD1234);
      xfer("d", 0);
      push_ok(); xfer("5", 0);
      check("d5_disp", 32'(disp), 32'h1234);
      xfer("D", 0);
      push_err(); xfer("9", 0);
      check("d9_disp", 32'(disp), 32'h1234);

      // bad input and ignored bytes
      push_err(); xfer("x", 0);
      check("x_bytes", 32'(tx_cnt), 32'd3);
      xfer("r", 0);
      check("arg_led", 32'(led[1]), 32'd1);
      push_err(); xfer("Z", 0);
      xfer(8'h0d, 0); check("cr_quiet", 32'(tx_cnt), 32'd0);
      xfer(8'h0a, 0); check("lf_quiet", 32'(tx_cnt), 32'd0);
      xfer(8'h20, 0); check("sp_quiet", 32'(tx_cnt), 32'd0);
      check("idle_led", 32'(led), 32'd0);

      // argument timeout
      push_err(); xfer("r", 0);
      check("to_latency", 32'(lat), 32'(TO + 1));
      check("to_idle_led", 32'(led), 32'd0);

      // reset in the middle of a reply
      set_probe(3, 32'hDEADBEEF);
      push_ok(); xfer("h", 0);
      xfer("r", 0);
      rx_data = "3"; rx_valid = 1'b1; seen = 0;
      for (int cyc = 0; cyc < 500 && seen < 3; cyc++) begin
         @(negedge clk);
         if (rx_re) rx_valid = 1'b0;
         if (tx_we) seen++;
      end
      check("rst_mid_seen", 32'(seen), 32'd3);
      rstn = 1'b0; rx_valid = 1'b0;
      seen = 0;
      for (int cyc = 0; cyc < 6; cyc++) begin
         @(negedge clk);
         if (tx_we) seen++;
      end
      check("rst_mid_tx", 32'(seen), 32'd0);
      check("rst_mid_halt", 32'(cpu_halt), 32'd0);
      check("rst_mid_disp", 32'(disp), 32'h5A5A);
      check("rst_mid_led", 32'(led), 32'd0);
      rstn = 1'b1;
      repeat (2) @(negedge clk);
      xfer("r", 0);
      push_hex(32'h1111_5A5A);
      xfer("0", 0);
      check("r0_bytes", 32'(tx_cnt), 32'd10);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
